// File: rtl/data_mem_responder_if.sv
// data_mem_responder_if: request/response bundle between the writeback stage and data memory.
interface data_mem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        mem_stall;
    modport master(
        output req_valid, req_we, req_addr, req_wdata, req_be,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, mem_stall
    );
    modport slave(
        input  req_valid, req_we, req_addr, req_wdata, req_be,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, mem_stall
    );
endinterface

// File: rtl/data_mem_responder.sv
// data_mem_responder: serialised load/store responder on a word-addressed SRAM with programmable load wait states.
module data_mem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned WAIT_STATES = 0
) (
    input logic clk,
    input logic reset,
    data_mem_responder_if.slave bus
);
    localparam int AW = $clog2(DEPTH_WORDS);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
    state_t      state, next_state;
    logic [31:0] mem [DEPTH_WORDS];
    logic [31:0] offset, word_off, rdata;
    logic [AW-1:0] idx;
    logic [3:0]  cnt;
    logic        err, bad, accept;
    // Unsigned subtraction makes addresses below the base wrap to huge offsets.
    assign offset   = bus.req_addr - BASE_ADDR;
    assign word_off = offset >> 2;
    assign bad      = (bus.req_addr[1:0] != 2'b00) || (word_off >= DEPTH_WORDS);
    assign accept   = bus.req_valid && state == IDLE;
    assign bus.req_ready = state == IDLE;
    assign bus.rsp_valid = state == RESP;
    assign bus.rsp_rdata = rdata;
    assign bus.rsp_err   = err;
    assign bus.mem_stall = bus.req_valid && state != IDLE;
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    next_state = accept ? ((bad || bus.req_we) ? RESP : ACCESS) : IDLE;
            ACCESS:  next_state = (cnt == 4'd0) ? RESP : ACCESS;
            default: next_state = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else state <= next_state;
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt   <= 4'd0;
            idx   <= '0;
            rdata <= 32'd0;
            err   <= 1'b0;
        end else if (accept) begin
            err   <= bad;
            rdata <= 32'd0;
            idx   <= word_off[AW-1:0];
            cnt   <= 4'(WAIT_STATES);
        end else if (state == ACCESS) begin
            if (cnt != 4'd0) cnt <= cnt - 4'd1;
            else rdata <= mem[idx];
        end
    end
    // The array has no reset so contents survive an aborted transaction.
    always_ff @(posedge clk) begin
        if (accept && bus.req_we && !bad)
            for (int i = 0; i < 4; i++)
                if (bus.req_be[i]) mem[word_off[AW-1:0]][8*i +: 8] <= bus.req_wdata[8*i +: 8];
    end
endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: two responders (no wait states / three wait states) driven through one muxed master.
module tb_data_mem_responder;
    localparam int DEPTH = 256;
    localparam logic [31:0] BASE0 = 32'h0000_0000;
    localparam logic [31:0] BASE1 = 32'h0000_0400;
    localparam int WS0 = 0;
    localparam int WS1 = 3;
    logic        clk = 0, reset = 1, sel = 0;
    logic        req_valid = 0, req_we = 0;
    logic [31:0] req_addr = 0, req_wdata = 0;
    logic [3:0]  req_be = 0;
    logic        req_ready, rsp_valid, rsp_err, mem_stall;
    logic [31:0] rsp_rdata;
    int          checks = 0, errors = 0, cyc = 0;
    logic [31:0] mdl [2][DEPTH];
    bit          wr  [2][DEPTH];
    int          last_acc = -1, last_lat = 0, acc_cyc = 0, got_lat = 0, waited = 0;
    logic        last_sel = 0, got_err;
    logic [31:0] got_rdata;
    data_mem_responder_if b0();
    data_mem_responder_if b1();
    assign b0.req_valid = req_valid && !sel;
    assign b1.req_valid = req_valid && sel;
    assign b0.req_we = req_we;
    assign b1.req_we = req_we;
    assign b0.req_addr = req_addr;
    assign b1.req_addr = req_addr;
    assign b0.req_wdata = req_wdata;
    assign b1.req_wdata = req_wdata;
    assign b0.req_be = req_be;
    assign b1.req_be = req_be;
    assign req_ready = sel ? b1.req_ready : b0.req_ready;
    assign rsp_valid = sel ? b1.rsp_valid : b0.rsp_valid;
    assign rsp_rdata = sel ? b1.rsp_rdata : b0.rsp_rdata;
    assign rsp_err   = sel ? b1.rsp_err : b0.rsp_err;
    assign mem_stall = sel ? b1.mem_stall : b0.mem_stall;
    data_mem_responder #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE0), .WAIT_STATES(WS0)) dut0 (.clk(clk), .reset(reset), .bus(b0));
    data_mem_responder #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE1), .WAIT_STATES(WS1)) dut1 (.clk(clk), .reset(reset), .bus(b1));
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask
    function automatic bit exp_bad(input int s, input logic [31:0] a);
        longint lo = longint'({32'h0, (s == 1) ? BASE1 : BASE0});
        longint av = longint'({32'h0, a});
        return a[1:0] != 2'b00 || av < lo || av >= lo + 4 * DEPTH;
    endfunction
    // Holds req_valid through the busy cycles so mem_stall can be observed.
    task automatic xact(input logic we, input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        int k = 0;
        bit done = 0;
        @(negedge clk);
        req_valid = 1; req_we = we; req_addr = a; req_wdata = d; req_be = be;
        #1;
        while (!req_ready && k < 40) begin
            @(negedge clk); #1; k++;
        end
        waited = k;
        check("stall_accept", 32'(mem_stall), 32'd0);
        @(posedge clk); #1;
        acc_cyc = cyc;
        k = 0;
        while (!done && k < 40) begin
            @(negedge clk); k++;
            check("stall_busy", 32'(mem_stall), 32'd1);
            done = rsp_valid;
        end
        check("rsp_seen", 32'(done), 32'd1);
        got_rdata = rsp_rdata; got_err = rsp_err; got_lat = k;
        req_valid = 0;
    endtask
    task automatic op(input int s, input logic we, input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        bit bad;
        int w, lat;
        logic [31:0] base, mask;
        sel = s[0];
        base = s[0] ? BASE1 : BASE0;
        bad = exp_bad(s, a);
        w = int'((a - base) >> 2);
        xact(we, a, d, be);
        lat = (bad || we) ? 1 : 2 + (s[0] ? WS1 : WS0);
        check("err", 32'(got_err), 32'(bad));
        check("latency", got_lat, lat);
        if (last_acc >= 0 && last_sel == s[0]) check("gap", acc_cyc - last_acc, last_lat + 1);
        last_acc = acc_cyc; last_lat = lat; last_sel = s[0];
        if (bad || we) check("rdata_zero", got_rdata, 32'd0);
        else if (wr[s][w]) check("rdata", got_rdata, mdl[s][w]);
        if (we && !bad) begin
            mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
            mdl[s][w] = (mdl[s][w] & ~mask) | (d & mask);
            wr[s][w] = wr[s][w] || be == 4'hF;
        end
    endtask
    initial begin
        int s, r;
        logic [31:0] a, base;
        #1 reset = 0;
        req_valid = 1; req_we = 1; req_addr = 32'h10; req_wdata = 32'h1234_5678; req_be = 4'hF;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            check("rst_ready", 32'(req_ready), 32'd1);
            check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
            check("rst_rdata", rsp_rdata, 32'd0);
            check("rst_stall", 32'(mem_stall), 32'd0);
        end
        req_valid = 0;
        reset = 1;
        op(0, 1, 32'h10, 32'h1234_5678, 4'hF);
        check("first_edge_accept", waited, 0);
        op(0, 1, 32'h20, 32'hDEAD_BEEF, 4'hF);
        op(0, 0, 32'h20, 32'h0, 4'h0);
        check("ld_deadbeef", got_rdata, 32'hDEAD_BEEF);
        op(0, 1, 32'h24, 32'h1122_3344, 4'hF);
        op(0, 1, 32'h24, 32'hAABB_CCDD, 4'b0101);
        op(0, 0, 32'h24, 32'h0, 4'h0);
        check("be_merge", got_rdata, 32'h11BB_33DD);
        op(0, 0, 32'h22, 32'h0, 4'h0);
        op(0, 1, 32'h0, 32'hCAFE_F00D, 4'hF);
        op(0, 1, BASE0 + 4 * DEPTH, 32'hFFFF_FFFF, 4'hF);
        op(0, 0, 32'h0, 32'h0, 4'h0);
        check("word0_kept", got_rdata, 32'hCAFE_F00D);
        op(1, 1, BASE1 + 32'h20, 32'h5A5A_A5A5, 4'hF);
        op(1, 0, BASE1 + 32'h20, 32'h0, 4'h0);
        check("ws3_lat", got_lat, 5);
        op(1, 0, BASE1 + 32'h20, 32'h0, 4'h0);
        op(1, 0, BASE1 - 32'h4, 32'h0, 4'h0);
        sel = 1;
        @(negedge clk);
        req_valid = 1; req_we = 0; req_addr = BASE1 + 32'h20; req_be = 4'h0;
        #1 check("mid_ready", 32'(req_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        @(negedge clk);
        reset = 0; req_valid = 0;
        #1;
        check("mid_rst_ready", 32'(req_ready), 32'd1);
        check("mid_rst_rsp", 32'(rsp_valid), 32'd0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (i == 2) reset = 1;
            #1 check("mid_no_rsp", 32'(rsp_valid), 32'd0);
        end
        last_acc = -1;
        op(1, 0, BASE1 + 32'h20, 32'h0, 4'h0);
        check("after_rst_data", got_rdata, 32'h5A5A_A5A5);
        for (int i = 0; i < 16; i++) begin
            op(0, 1, BASE0 + 32'(4 * i), $urandom, 4'hF);
            op(1, 1, BASE1 + 32'(4 * i), $urandom, 4'hF);
        end
        for (int n = 0; n < 80; n++) begin
            s = int'($urandom_range(1, 0));
            r = int'($urandom_range(9, 0));
            base = (s == 1) ? BASE1 : BASE0;
            a = base + 4 * $urandom_range(15, 0);
            if (r == 0) a = a + $urandom_range(3, 1);
            else if (r == 1) a = base + 4 * DEPTH + 4 * $urandom_range(3, 0);
            else if (r == 2) a = base - 32'h4;
            op(s, 1'($urandom_range(1, 0)), a, $urandom, 4'($urandom));
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

Memory-side responder for the core's data-memory port. It accepts one load or store request at a time from the writeback stage over a valid/ready handshake and performs it on an internal word-addressed SRAM array. Loads are answered after a programmable number of wait states; stores are acknowledged. The block also drives the stall request the hazard control unit uses to freeze the pipeline while an access is outstanding.

## Interface

Parameters:
- DEPTH_WORDS, 1024: number of 32-bit words in the array; power of two, 16..65536.
- BASE_ADDR, 32'h0000_0000: byte address of word 0; word-aligned.
- WAIT_STATES, 0: extra ACCESS cycles per load; 0..15.

Ports (clock and reset first):
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- req_valid  input  1  request present; held stable until accepted.
- req_ready  output  1  block can accept a request this cycle.
- req_we  input  1  1 = store, 0 = load.
- req_addr  input  32  byte address (the core's ALUResultW).
- req_wdata  input  32  store data (the core's WD).
- req_be  input  4  store byte enables; bit i gates byte i, which is wdata[8i+7:8i].
- rsp_valid  output  1  one-cycle response pulse.
- rsp_rdata  output  32  load data (the core's ReadData); 0 for stores and errors.
- rsp_err  output  1  qualified by rsp_valid; set for a misaligned or out-of-range access.
- mem_stall  output  1  combinational: req_valid && !req_ready.

## Operation

- FSM states are IDLE, ACCESS and RESP. The reset state is IDLE.
- req_ready is 1 only in IDLE. A request is accepted on any rising edge where req_valid && req_ready.
- An access is in error if req_addr[1:0] != 0, or if (req_addr − BASE_ADDR) >> 2 >= DEPTH_WORDS. The subtraction is unsigned 32-bit, so an address below BASE_ADDR wraps and is out of range.
- Error request, store or load:
  - Memory is left unchanged.
  - Next state is RESP with rsp_err=1 and rsp_rdata=0.
- Valid store:
  - At the accept edge, write each enabled byte of the word at index (req_addr − BASE_ADDR)>>2.
  - Next state is RESP with rsp_err=0 and rsp_rdata=0.
  - req_be=0 is legal. It changes no bytes and is acknowledged normally.
- Valid load:
  - At the accept edge, latch the word index and load the wait counter with WAIT_STATES.
  - Next state is ACCESS.
  - req_be is ignored.
- ACCESS:
  - If the counter != 0, decrement it and stay in ACCESS.
  - If the counter == 0, register the full array word into the read-data register and go to RESP.
- RESP:
  - rsp_valid=1 for exactly one cycle, then return to IDLE.
  - There is no response backpressure.
- rsp_rdata and rsp_err hold their values outside RESP but are meaningful only while rsp_valid=1.
- Array contents are not initialised and are not cleared by reset. The bench must write before it reads.

## Timing

- Reset (asserted low) forces, asynchronously:
  - state=IDLE, req_ready=1, rsp_valid=0;
  - rsp_rdata=0, rsp_err=0, wait counter=0.
- mem_stall follows req_valid combinationally.
- Reset during ACCESS or RESP abandons the transaction and no response is issued. A store already written at its accept edge stays written.
- Latency is counted from the accept edge to the cycle in which rsp_valid is high:
  - stores and errors: 1 cycle;
  - loads: 2+WAIT_STATES cycles.
- Throughput:
  - one store every 2 cycles;
  - one load every 3+WAIT_STATES cycles;
  - req_ready is low in ACCESS and RESP.
- Read-after-write to the same address returns the new data. There is no bypass path; this holds because requests are serialised.
- mem_stall is high in every cycle in which req_valid=1 and the block is not in IDLE. It is low in the accept cycle itself.

## Test plan

- Reset: hold reset=0 for 3 cycles with req_valid=1.
  - Required: req_ready=1, rsp_valid=0, rsp_rdata=0, mem_stall=0.
  - After release, a store to 0x10 is accepted on the first edge.
- Store then load, WAIT_STATES=0:
  - Store 0xDEADBEEF to 0x20 with be=4'hF. Required: rsp_valid 1 cycle after accept, rsp_err=0.
  - Then load 0x20. Required: rsp_valid 2 cycles after accept with rdata=0xDEADBEEF, and mem_stall=1 for the 2 intervening cycles.
- Byte enables:
  - Store 0x11223344 to 0x24 with be=4'hF, then 0xAABBCCDD with be=4'b0101.
  - Required: a load of 0x24 returns 0x11BB33DD.
- Errors:
  - A load of 0x22 returns rsp_err=1 and rdata=0 after 1 cycle.
  - A store to BASE_ADDR+4·DEPTH_WORDS returns rsp_err=1, and a later load of word 0 is unchanged.
- Wait states, WAIT_STATES=3:
  - A load of 0x20 returns rsp_valid exactly 5 cycles after accept.
  - A back-to-back second load is accepted no earlier than 6 cycles after the first.
- Reset mid-load:
  - Assert reset in the second ACCESS cycle.
  - Required: rsp_valid never pulses for that load, req_ready=1 immediately, and a subsequent load returns the previously stored data.
